// File: rtl/seq_alu_param.sv
// Multi-cycle ALU with an internal accumulator and a start/busy/done handshake.
// MUL and non-zero shifts iterate one step per cycle. All other ops finish on the accept edge.
module seq_alu_param #(
  parameter int DATA_W  = 16,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [DATA_W-1:0]  a_bus,
  input  logic [DATA_W-1:0]  b_bus,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               use_ac,
  input  logic               write_ac,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  c_bus,
  output logic               z_flag,
  output logic               c_flag,
  output logic [DATA_W-1:0]  ac
);

  localparam int CNT_W = (SHIFT_W > $clog2(DATA_W + 1)) ? SHIFT_W : $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] MUL_TGT = CNT_W'(DATA_W);

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_AVG  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, tgt_q, tgt_d;
  logic [2:0]            op_q, op_d;
  logic                  wac_q, wac_d;
  logic [DATA_W-1:0]     work_q, work_d, mplier_q, mplier_d;
  logic [2*DATA_W-1:0]   mcand_q, mcand_d, prod_q, prod_d;
  logic [DATA_W-1:0]     c_bus_q, c_bus_d, ac_q, ac_d;
  logic                  z_q, z_d, cf_q, cf_d, done_q, done_d;

  logic [DATA_W-1:0]     a_sel_s, res_s;
  logic [DATA_W:0]       sum_s, diff_s, inc_s;
  logic [2*DATA_W-1:0]   prod_nx_s;
  logic [CNT_W-1:0]      cnt_inc_s;
  logic                  cout_s, fin_s, wac_s;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    op_d     = op_q;
    wac_d    = wac_q;
    work_d   = work_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    c_bus_d  = c_bus_q;
    z_d      = z_q;
    cf_d     = cf_q;
    ac_d     = ac_q;
    done_d   = 1'b0;
    res_s    = {DATA_W{1'b0}};
    cout_s   = 1'b0;
    fin_s    = 1'b0;
    wac_s    = wac_q;
    a_sel_s  = use_ac ? ac_q : a_bus;
    sum_s    = {1'b0, a_sel_s} + {1'b0, b_bus};
    diff_s   = {1'b0, a_sel_s} - {1'b0, b_bus};
    inc_s    = {1'b0, a_sel_s} + {{DATA_W{1'b0}}, 1'b1};
    prod_nx_s = prod_q;
    cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          wac_d    = write_ac;
          wac_s    = write_ac;
          cnt_d    = {CNT_W{1'b0}};
          work_d   = a_sel_s;
          mplier_d = b_bus;
          mcand_d  = {{DATA_W{1'b0}}, a_sel_s};
          prod_d   = {(2*DATA_W){1'b0}};
          case (op)
            OP_PASS: begin fin_s = 1'b1; res_s = b_bus; end
            OP_ADD:  begin fin_s = 1'b1; res_s = sum_s[DATA_W-1:0]; cout_s = sum_s[DATA_W]; end
            OP_SUB:  begin fin_s = 1'b1; res_s = diff_s[DATA_W-1:0]; cout_s = diff_s[DATA_W]; end
            OP_INC:  begin fin_s = 1'b1; res_s = inc_s[DATA_W-1:0]; cout_s = inc_s[DATA_W]; end
            OP_AVG:  begin fin_s = 1'b1; res_s = sum_s[DATA_W:1]; end
            OP_MUL:  begin tgt_d = MUL_TGT; state_d = EXEC; end
            OP_SHL, OP_SHR: begin
              if (shift != {SHIFT_W{1'b0}}) begin
                tgt_d   = CNT_W'(shift);
                state_d = EXEC;
              end else begin
                fin_s = 1'b1;
                res_s = a_sel_s;
              end
            end
            default: begin fin_s = 1'b1; res_s = b_bus; end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        cnt_d = cnt_inc_s;
        case (op_q)
          OP_MUL: begin
            // Shift-add: one multiplier bit consumed per cycle, LSB first.
            prod_nx_s = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
            prod_d    = prod_nx_s;
            mcand_d   = {mcand_q[2*DATA_W-2:0], 1'b0};
            mplier_d  = {1'b0, mplier_q[DATA_W-1:1]};
            res_s     = prod_nx_s[DATA_W-1:0];
            cout_s    = |prod_nx_s[2*DATA_W-1:DATA_W];
          end
          OP_SHL: begin
            work_d = {work_q[DATA_W-2:0], 1'b0};
            res_s  = {work_q[DATA_W-2:0], 1'b0};
            cout_s = work_q[DATA_W-1];
          end
          OP_SHR: begin
            work_d = {1'b0, work_q[DATA_W-1:1]};
            res_s  = {1'b0, work_q[DATA_W-1:1]};
            cout_s = work_q[0];
          end
          default: res_s = work_q;
        endcase
        if (cnt_inc_s == tgt_q) begin
          fin_s   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = EXEC;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin_s) begin
      c_bus_d = res_s;
      z_d     = (res_s == {DATA_W{1'b0}});
      cf_d    = cout_s;
      done_d  = 1'b1;
      if (wac_s) begin
        ac_d = res_s;
      end else begin
        ac_d = ac_q;
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      tgt_q    <= {CNT_W{1'b0}};
      op_q     <= 3'd0;
      wac_q    <= 1'b0;
      work_q   <= {DATA_W{1'b0}};
      mplier_q <= {DATA_W{1'b0}};
      mcand_q  <= {(2*DATA_W){1'b0}};
      prod_q   <= {(2*DATA_W){1'b0}};
      c_bus_q  <= {DATA_W{1'b0}};
      ac_q     <= {DATA_W{1'b0}};
      z_q      <= 1'b0;
      cf_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      op_q     <= op_d;
      wac_q    <= wac_d;
      work_q   <= work_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      c_bus_q  <= c_bus_d;
      ac_q     <= ac_d;
      z_q      <= z_d;
      cf_q     <= cf_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == EXEC);
  assign done   = done_q;
  assign c_bus  = c_bus_q;
  assign z_flag = z_q;
  assign c_flag = cf_q;
  assign ac     = ac_q;

endmodule

// File: tb/tb_seq_alu_param.sv
// Directed, table-driven bench for seq_alu_param (DATA_W=16, SHIFT_W=4).
module tb_seq_alu_param;

  logic        clk = 1'b0;
  logic        reset, start, use_ac, write_ac;
  logic [2:0]  op;
  logic [15:0] a_bus, b_bus;
  logic [3:0]  shift;
  logic        busy, done, z_flag, c_flag;
  logic [15:0] c_bus, ac;

  int checks = 0;
  int failures = 0;

  seq_alu_param #(.DATA_W(16), .SHIFT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_bus(a_bus), .b_bus(b_bus),
    .shift(shift), .use_ac(use_ac), .write_ac(write_ac), .busy(busy), .done(done),
    .c_bus(c_bus), .z_flag(z_flag), .c_flag(c_flag), .ac(ac)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sh;
    logic        uac;
    logic        wac;
    logic [15:0] exp_c;
    logic        exp_z;
    logic        exp_cf;
    int          exp_lat;
    logic [15:0] exp_ac;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one op, then count edges after the accept edge until done (and busy cycles seen).
  task automatic do_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] sh, input logic uac, input logic wac,
                       output int lat, output int bc);
    @(negedge clk);
    op = o; a_bus = a; b_bus = b; shift = sh; use_ac = uac; write_ac = wac; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    bc = 0;
    while (!done && lat < 200) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bc, ndone;

    vecs[0]  = '{3'd1, 16'hFFFF, 16'h0001, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0,  16'h0000};
    vecs[1]  = '{3'd2, 16'h0003, 16'h0005, 4'd0,  1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b1, 0,  16'h0000};
    vecs[2]  = '{3'd4, 16'h0123, 16'h0010, 4'd0,  1'b0, 1'b0, 16'h1230, 1'b0, 1'b0, 16, 16'h0000};
    vecs[3]  = '{3'd4, 16'h8000, 16'h0004, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16, 16'h0000};
    vecs[4]  = '{3'd6, 16'h0001, 16'h0000, 4'd4,  1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 4,  16'h0000};
    vecs[5]  = '{3'd7, 16'h8000, 16'h0000, 4'd15, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 15, 16'h0000};
    vecs[6]  = '{3'd6, 16'hABCD, 16'h0000, 4'd0,  1'b0, 1'b0, 16'hABCD, 1'b0, 1'b0, 0,  16'h0000};
    vecs[7]  = '{3'd0, 16'h1234, 16'h00F0, 4'd0,  1'b0, 1'b1, 16'h00F0, 1'b0, 1'b0, 0,  16'h00F0};
    vecs[8]  = '{3'd5, 16'h5555, 16'h0011, 4'd0,  1'b1, 1'b1, 16'h0080, 1'b0, 1'b0, 0,  16'h0080};
    vecs[9]  = '{3'd3, 16'hFFFF, 16'h0000, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0,  16'h0080};
    vecs[10] = '{3'd7, 16'h0003, 16'h0000, 4'd1,  1'b0, 1'b0, 16'h0001, 1'b0, 1'b1, 1,  16'h0080};
    vecs[11] = '{3'd6, 16'hC000, 16'h0000, 4'd2,  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 2,  16'h0080};
    vecs[12] = '{3'd5, 16'hFFFF, 16'hFFFF, 4'd0,  1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0,  16'h0080};
    vecs[13] = '{3'd4, 16'h0000, 16'h0003, 4'd0,  1'b1, 1'b1, 16'h0180, 1'b0, 1'b0, 16, 16'h0180};

    reset = 1'b1; start = 1'b0; op = 3'd0; a_bus = 16'h0; b_bus = 16'h0;
    shift = 4'd0; use_ac = 1'b0; write_ac = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cbus", {16'h0, c_bus}, 32'h0);
    chk("rst_ac", {16'h0, ac}, 32'h0);
    chk("rst_flags", {29'h0, z_flag, c_flag, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].uac, vecs[i].wac, lat, bc);
      chk($sformatf("v%0d_done", i), {31'h0, done}, 32'h1);
      chk($sformatf("v%0d_cbus", i), {16'h0, c_bus}, {16'h0, vecs[i].exp_c});
      chk($sformatf("v%0d_z", i), {31'h0, z_flag}, {31'h0, vecs[i].exp_z});
      chk($sformatf("v%0d_c", i), {31'h0, c_flag}, {31'h0, vecs[i].exp_cf});
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_busy", i), bc, vecs[i].exp_lat);
      chk($sformatf("v%0d_busy_at_done", i), {31'h0, busy}, 32'h0);
      chk($sformatf("v%0d_ac", i), {16'h0, ac}, {16'h0, vecs[i].exp_ac});
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), {31'h0, done}, 32'h0);
    end

    // Back-to-back single-cycle ops give done on consecutive cycles.
    @(negedge clk);
    op = 3'd1; a_bus = 16'h0001; b_bus = 16'h0002; use_ac = 1'b0; write_ac = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_done1", {31'h0, done}, 32'h1);
    chk("b2b_cbus1", {16'h0, c_bus}, 32'h3);
    @(negedge clk);
    op = 3'd0; b_bus = 16'h0005;
    @(posedge clk); #1;
    chk("b2b_done2", {31'h0, done}, 32'h1);
    chk("b2b_cbus2", {16'h0, c_bus}, 32'h5);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done3", {31'h0, done}, 32'h0);

    // start held through the whole MUL busy window, including its last cycle, is ignored.
    @(negedge clk);
    op = 3'd4; a_bus = 16'h0002; b_bus = 16'h0003; use_ac = 1'b0; write_ac = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    op = 3'd0; b_bus = 16'h7777; write_ac = 1'b1;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("ign_lat", lat, 16);
    chk("ign_cbus", {16'h0, c_bus}, 32'h6);
    ndone = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("ign_extra_done", ndone, 0);
    chk("ign_ac", {16'h0, ac}, 32'h0180);

    // Reset during the 5th busy cycle of a MUL aborts it without a done.
    @(negedge clk);
    op = 3'd4; a_bus = 16'h0005; b_bus = 16'h0005; write_ac = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_before", {31'h0, busy}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_ac", {16'h0, ac}, 32'h0);
    chk("abort_cbus", {16'h0, c_bus}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("abort_quiet", ndone, 0);

    do_op(3'd3, 16'h0007, 16'h0000, 4'd0, 1'b0, 1'b0, lat, bc);
    chk("inc_done", {31'h0, done}, 32'h1);
    chk("inc_cbus", {16'h0, c_bus}, 32'h0008);
    chk("inc_lat", lat, 0);
    chk("inc_ac", {16'h0, ac}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu_param.md
# seq_alu_param

Parametrised, multi-cycle successor to the processor's single-cycle ALU. It executes the eight-operation datapath set, including iterative multiply and variable shifts, under a start/busy/done handshake. It holds an internal accumulator (AC) that can source operand A and capture results. It sits between the A/B buses and the C bus of the down-sampling CPU and is driven by the control unit.

## Interface
Parameters:
- DATA_W, 16, datapath width (≥ 4)
- SHIFT_W, 4, shift-amount width

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- op  in  3  operation code, latched on accept
- a_bus  in  DATA_W  operand A
- b_bus  in  DATA_W  operand B
- shift  in  SHIFT_W  shift amount, latched on accept
- use_ac  in  1  on accept: operand A = AC instead of a_bus
- write_ac  in  1  on accept: result is written to AC at done
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse: result/flags valid
- c_bus  out  DATA_W  result register, held until next done
- z_flag  out  1  result == 0, updated with done
- c_flag  out  1  carry/borrow/overflow, updated with done
- ac  out  DATA_W  accumulator contents

## Operation
- Op codes (all unsigned, results truncated to DATA_W):
  - 000 PASS = B
  - 001 ADD = A+B; c = carry out
  - 010 SUB = A−B; c = borrow (A<B)
  - 011 INC = A+1; c = carry out
  - 100 MUL = low DATA_W of A×B, shift-add, one bit per cycle; c = 1 if high half ≠ 0
  - 101 AVG = (A+B)>>1, computed from the DATA_W+1-bit sum, truncating; c = 0
  - 110 SHL = A<<shift, one position per cycle; c = last bit shifted out (0 if shift=0)
  - 111 SHR = logical A>>shift, one position per cycle; c = last bit shifted out
- FSM: IDLE, EXEC.
  - IDLE→EXEC on accept of MUL, or of SHL/SHR with shift≠0.
  - EXEC→IDLE when the iteration counter reaches its target.
  - All other ops, and shifts with shift=0, complete directly from IDLE.
- Iteration target: MUL = DATA_W; SHL/SHR = the latched shift value. A shift ≥ DATA_W naturally yields 0.
- AC:
  - Written with the result on the done edge only when write_ac was latched 1.
  - use_ac selects AC as operand A, sampled at the accept edge.
- start while busy=1 is ignored. There is no queue and no error.
- reset clears c_bus, ac, z_flag, c_flag, busy, done, the counter and the FSM (→IDLE). It aborts any op in flight; no done is issued for the aborted op.
- op, operands and mode bits are don't-care except at the accept edge.

## Timing
- Accept edge E0 is a rising edge with start=1, busy=0, reset=0.
- Single-cycle ops: c_bus, flags and AC are registered at E0. done=1 for the cycle after E0. busy stays 0. Back-to-back starts on consecutive cycles produce done on consecutive cycles.
- Iterative ops (N iterations):
  - busy=1 from after E0.
  - Iterations occur at E1…EN.
  - At EN: result, flags and AC are registered, done=1, and busy=0, all during the cycle after EN.
  - Latency is N cycles from accept to done.
- start asserted during the last busy cycle is ignored. The earliest next accept is EN+1.
- done is never high for two consecutive cycles from one op.
- Reset values: every output is 0.

## Test plan
- Reset: hold reset 2 cycles mid-random traffic → c_bus=0, ac=0, z=c=0, busy=0, done=0.
- ADD 0xFFFF+0x0001 → c_bus=0x0000, z=1, c=1, done 1 cycle after accept, busy never high. SUB 0x0003−0x0005 → 0xFFFE, c=1, z=0.
- MUL 0x0123×0x0010 → 0x1230, busy exactly 16 cycles, done at E16, c=0. MUL 0x8000×0x0004 → 0x0000, z=1, c=1.
- SHL 0x0001 by 4 → 0x0010 at E4. SHR 0x8000 by 15 → 0x0001 at E15, c=0. SHL 0xABCD by 0 → 0xABCD single-cycle, c=0.
- AC chaining: PASS b=0x00F0 with write_ac → ac=0x00F0. Then AVG use_ac, b=0x0011, write_ac → c_bus=ac=0x0080. A start pulsed during a MUL's busy window is ignored and produces no extra done.
- Reset at the 5th busy cycle of MUL → busy=0 next cycle, no done, ac=0. A following INC a=0x0007 completes normally → 0x0008.
